// File: rtl/stream_lane_packer.sv
// stream_lane_packer
//   Packs Ratio consecutive narrow beats into one wide beat of Ratio lanes.
//   A last_i beat closes a partial word early. strb_o marks the filled lanes
//   as a thermometer code from lane 0. The output is registered once, which
//   cuts the path from the upstream FIFO to the wide consumer.
// Ports
//   clk_i, rst_ni         clock, async active-low reset
//   flush_i               sync clear of all state (beats all handshakes)
//   data_i/last_i         narrow payload / close-current-word flag
//   valid_i/ready_o       narrow handshake
//   data_o/strb_o/last_o  wide payload / lane strobe / closed-by-last
//   valid_o/ready_i       wide handshake

// One lane: accumulator slot plus output register slot.
module stream_lane_packer_lane #(
  parameter type type_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  i_flush,
  input  logic  i_wr,     // non-closing beat lands in this lane
  input  logic  i_close,  // closing beat accepted this cycle
  input  logic  i_drop,   // pop with no new word behind it
  input  logic  i_sel,    // this lane is the current lane index
  input  logic  i_fill,   // this lane is at or below the current lane index
  input  type_t i_data,
  output type_t o_data
);
  type_t r_acc;
  type_t r_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      if (i_close)   r_acc <= '0;
      else if (i_wr) r_acc <= i_data;
      // Lanes above the closing index load 0 so no stale data leaks out.
      if (i_close)     r_out <= i_fill ? (i_sel ? i_data : r_acc) : '0;
      else if (i_drop) r_out <= '0;
    end
  end

  assign o_data = r_out;
endmodule

module stream_lane_packer #(
  parameter int unsigned Ratio = 4,
  parameter type type_t = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  type_t                 data_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output type_t [Ratio-1:0]     data_o,
  output logic  [Ratio-1:0]     strb_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i
);
  localparam int unsigned CW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [Ratio-1:0] LSB = {{(Ratio-1){1'b0}}, 1'b1};

  logic [CW-1:0]    r_cnt;
  logic [Ratio-1:0] r_strb;
  logic             r_last;
  logic             r_valid;

  logic             w_accept;
  logic             w_close;
  logic             w_pop;
  logic [Ratio-1:0] w_sel;
  logic [Ratio-1:0] w_fill;

  // Stall blocks every beat, closing or not, so ready never looks at valid_i.
  assign ready_o  = !flush_i && (!r_valid || ready_i);
  assign w_accept = valid_i && ready_o;
  assign w_close  = w_accept && ((r_cnt == CW'(Ratio-1)) || last_i);
  assign w_pop    = r_valid && ready_i;

  for (genvar k = 0; k < Ratio; k++) begin : g_lane
    assign w_sel[k]  = (r_cnt == CW'(k));
    assign w_fill[k] = (CW'(k) <= r_cnt);

    stream_lane_packer_lane #(.type_t(type_t)) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_flush (flush_i),
      .i_wr    (w_accept && w_sel[k] && !w_close),
      .i_close (w_close),
      .i_drop  (w_pop && !w_close),
      .i_sel   (w_sel[k]),
      .i_fill  (w_fill[k]),
      .i_data  (data_i),
      .o_data  (data_o[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_cnt   <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_close) begin
        // A new word replaces a word popped in the same cycle: no bubble.
        r_cnt   <= '0;
        r_strb  <= w_fill;
        r_last  <= last_i;
        r_valid <= 1'b1;
      end else begin
        if (w_accept) r_cnt <= r_cnt + 1'b1;
        if (w_pop) begin
          r_strb  <= '0;
          r_last  <= 1'b0;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign strb_o  = r_strb;
  assign last_o  = r_last;
  assign valid_o = r_valid;

  a_stall_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_valid && !ready_i && !flush_i) |=>
      (r_valid && $stable(data_o) && $stable(strb_o) && $stable(last_o)));

  a_strb_thermo: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((strb_o & (strb_o + LSB)) == '0));
endmodule
